// File: rtl/axi4_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4_slave_regfile
//
// Purpose:
//   AXI4-style single-beat slave backed by a small word-addressed register
//   file. The write address and write data may arrive in any order. Each
//   write receives a response. Reads return data one cycle after the address
//   handshake. Every response is held until the master accepts it. The write
//   and read FSMs are independent of each other. All outputs are registered.
//
// Parameters:
//   ADDR_W    address width
//   DATA_W    data width
//   NUM_REGS  number of registers (power of two, >= 2)
//   BASE_ADDR byte address of register 0 (aligned to 4*NUM_REGS)
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-high reset
//   awaddr/awvalid/awready   write address channel
//   wdata/wvalid/wready      write data channel
//   bvalid/bready            write response channel
//   araddr/arvalid/arready   read address channel
//   rdata/rvalid/rready      read data channel
//   bresp/rresp              response codes (only with AXI4_SLAVE_RESP_EN)
//
// Configuration macro:
//   AXI4_SLAVE_RESP_EN  Adds the bresp/rresp ports.
//                       Misaligned or out-of-range accesses return SLVERR.
//                       Misaligned writes are dropped.
//                       Misaligned reads return 0.
// ---------------------------------------------------------------------------
module axi4_slave_regfile #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
`ifdef AXI4_SLAVE_RESP_EN
  output logic [1:0]        bresp,
  output logic [1:0]        rresp,
`endif
  input  logic              rready
);

  localparam int                IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * NUM_REGS);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  wr_state_e         wr_state_q;
  rd_state_e         rd_state_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              awready_q, wready_q, bvalid_q;
  logic              arready_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              aw_got_q, w_got_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              aw_fire, w_fire, aw_have, w_have, wr_commit, wr_ok;
  logic [ADDR_W-1:0] wr_addr_d, wr_off;
  logic [DATA_W-1:0] wr_data_d;
  logic [IDX_W-1:0]  wr_idx;

  logic              ar_fire, rd_ok;
  logic [ADDR_W-1:0] rd_off;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

`ifdef AXI4_SLAVE_RESP_EN
  logic [1:0] bresp_q, rresp_q;
`endif

  // ---------------- write-side combinational helpers ----------------
  always_comb begin
    aw_fire = (wr_state_q == WR_IDLE) && awvalid && awready_q;
    w_fire  = (wr_state_q == WR_IDLE) && wvalid && wready_q;
    // "have" is true once a channel has been captured, either at an
    // earlier edge or at the current one.
    aw_have   = aw_got_q || aw_fire;
    w_have    = w_got_q || w_fire;
    wr_addr_d = aw_fire ? awaddr : awaddr_q;
    wr_data_d = w_fire ? wdata : wdata_q;
    // Unsigned subtraction wraps addresses below BASE_ADDR to large
    // offsets, so a single compare covers both range bounds.
    wr_off    = wr_addr_d - BASE_ADDR;
    wr_idx    = wr_off[IDX_W+1:2];
    wr_ok     = (wr_off < SPAN);
`ifdef AXI4_SLAVE_RESP_EN
    wr_ok     = wr_ok && (wr_off[1:0] == 2'b00);
`endif
    wr_commit = (wr_state_q == WR_IDLE) && aw_have && w_have;
  end

  // ---------------- read-side combinational helpers ----------------
  always_comb begin
    ar_fire = (rd_state_q == RD_IDLE) && arvalid && arready_q;
    rd_off  = araddr - BASE_ADDR;
    rd_idx  = rd_off[IDX_W+1:2];
    rd_ok   = (rd_off < SPAN);
`ifdef AXI4_SLAVE_RESP_EN
    rd_ok   = rd_ok && (rd_off[1:0] == 2'b00);
`endif
    // Reads regs_q before any same-edge write lands, so a colliding
    // read returns the old register contents.
    rd_word = rd_ok ? regs_q[rd_idx] : '0;
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit && wr_ok) begin
      regs_q[wr_idx] <= wr_data_d;
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef AXI4_SLAVE_RESP_EN
      bresp_q    <= 2'b00;
`endif
    end else if (wr_state_q == WR_IDLE) begin
      if (aw_fire) awaddr_q <= awaddr;
      if (w_fire)  wdata_q  <= wdata;
      if (wr_commit) begin
        wr_state_q <= WR_RESP;
        bvalid_q   <= 1'b1;
        awready_q  <= 1'b0;
        wready_q   <= 1'b0;
        aw_got_q   <= 1'b0;
        w_got_q    <= 1'b0;
`ifdef AXI4_SLAVE_RESP_EN
        bresp_q    <= wr_ok ? 2'b00 : 2'b10;
`endif
      end else begin
        // A channel stays ready until it has been captured. This branch
        // also raises both readies on the first edge after reset.
        aw_got_q  <= aw_have;
        w_got_q   <= w_have;
        awready_q <= !aw_have;
        wready_q  <= !w_have;
      end
    end else begin
      if (bready) begin
        wr_state_q <= WR_IDLE;
        bvalid_q   <= 1'b0;
        awready_q  <= 1'b1;
        wready_q   <= 1'b1;
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef AXI4_SLAVE_RESP_EN
      rresp_q    <= 2'b00;
`endif
    end else if (rd_state_q == RD_IDLE) begin
      if (ar_fire) begin
        rd_state_q <= RD_DATA;
        rdata_q    <= rd_word;
        rvalid_q   <= 1'b1;
        arready_q  <= 1'b0;
`ifdef AXI4_SLAVE_RESP_EN
        rresp_q    <= rd_ok ? 2'b00 : 2'b10;
`endif
      end else begin
        arready_q <= 1'b1;
      end
    end else begin
      if (rready) begin
        rd_state_q <= RD_IDLE;
        rvalid_q   <= 1'b0;
        arready_q  <= 1'b1;
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
`ifdef AXI4_SLAVE_RESP_EN
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
`endif

endmodule

// File: tb/tb_axi4_slave_regfile.sv
module tb_axi4_slave_regfile;

  localparam int          NUM  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata;
`ifdef AXI4_SLAVE_RESP_EN
  logic [1:0]  bresp, rresp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axi4_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(NUM), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid),
`ifdef AXI4_SLAVE_RESP_EN
    .bresp(bresp), .rresp(rresp),
`endif
    .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register contents as plain words; transaction bookkeeping per channel.
  logic [31:0] mem [NUM];
  logic        m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [31:0] m_rdata = 0;
  logic        m_aw_pend = 0, m_w_pend = 0;
  logic [31:0] m_aw_addr = 0, m_w_data = 0;
`ifdef AXI4_SLAVE_RESP_EN
  logic [1:0]  m_bresp = 0, m_rresp = 0;
`endif

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned ua = a;
    bit ok = (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * NUM);
`ifdef AXI4_SLAVE_RESP_EN
    ok = ok && (a % 4 == 0);
`endif
    return ok;
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) mem[i] = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      m_rdata = 0; m_aw_pend = 0; m_w_pend = 0;
`ifdef AXI4_SLAVE_RESP_EN
      m_bresp = 0; m_rresp = 0;
`endif
    end else begin
      // Read is evaluated first so it observes contents before this edge's write.
      if (!m_rvalid) begin
        if (arvalid && m_arready) begin
          m_rdata   = addr_ok(araddr) ? mem[addr_idx(araddr)] : 32'h0;
`ifdef AXI4_SLAVE_RESP_EN
          m_rresp   = addr_ok(araddr) ? 2'b00 : 2'b10;
`endif
          m_rvalid  = 1;
          m_arready = 0;
        end else m_arready = 1;
      end else if (rready) begin
        m_rvalid  = 0;
        m_arready = 1;
      end
      if (!m_bvalid) begin
        if (awvalid && m_awready) begin m_aw_pend = 1; m_aw_addr = awaddr; end
        if (wvalid && m_wready)   begin m_w_pend  = 1; m_w_data  = wdata;  end
        if (m_aw_pend && m_w_pend) begin
          if (addr_ok(m_aw_addr)) mem[addr_idx(m_aw_addr)] = m_w_data;
`ifdef AXI4_SLAVE_RESP_EN
          m_bresp = addr_ok(m_aw_addr) ? 2'b00 : 2'b10;
`endif
          m_bvalid = 1; m_awready = 0; m_wready = 0;
          m_aw_pend = 0; m_w_pend = 0;
        end else begin
          m_awready = !m_aw_pend;
          m_wready  = !m_w_pend;
        end
      end else if (bready) begin
        m_bvalid = 0; m_awready = 1; m_wready = 1;
      end
    end
  end

  // Per-cycle comparison, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    chk("awready", {31'b0, awready}, {31'b0, m_awready});
    chk("wready",  {31'b0, wready},  {31'b0, m_wready});
    chk("bvalid",  {31'b0, bvalid},  {31'b0, m_bvalid});
    chk("arready", {31'b0, arready}, {31'b0, m_arready});
    chk("rvalid",  {31'b0, rvalid},  {31'b0, m_rvalid});
    if (m_rvalid) chk("rdata", rdata, m_rdata);
`ifdef AXI4_SLAVE_RESP_EN
    if (m_bvalid) chk("bresp", {30'b0, bresp}, {30'b0, m_bresp});
    if (m_rvalid) chk("rresp", {30'b0, rresp}, {30'b0, m_rresp});
`endif
  end

  // ---------------- stimulus tasks (entered and left at a negedge) ----------------
  task automatic wait_b();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      done = bvalid && bready;
      @(negedge clk);
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL b_timeout: got no bvalid required bvalid=1"); end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit aw_go, w_go;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 0;
      if (w_go)  wvalid  = 0;
    end
    if (awvalid || wvalid) begin
      n_checks++; n_fail++;
      $display("FAIL wr_timeout: got no handshake required awready/wready=1");
    end
    awvalid = 0; wvalid = 0;
    wait_b();
    $display("WRITE addr=%h data=%h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay, output logic [31:0] d);
    bit done = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = arready;
      @(negedge clk);
    end
    arvalid = 0;
    rready = (rdelay == 0);
    for (int i = 0; i < 50 && !rvalid; i++) @(negedge clk);
    if (!done || !rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL rd_timeout: got rvalid=%0b required rvalid=1", rvalid);
    end
    repeat (rdelay) @(negedge clk);
    rready = 1;
    d = rdata;
    @(negedge clk);
    $display("READ  addr=%h data=%h", a, d);
  endtask

  initial begin
    logic [31:0] rd;
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'b0, awready}, 32'h0);
    chk("rst_arready", {31'b0, arready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 0;
    @(negedge clk);
    chk("first_awready", {31'b0, awready}, 32'h1);
    chk("first_arready", {31'b0, arready}, 32'h1);

    // ---- aligned write then read ----
    do_write(32'h0, 32'h1234_5678);
    do_read(32'h0, 0, rd);
    chk("read_0x0", rd, 32'h1234_5678);

    // ---- W before AW ----
    wdata = 32'hCAFE_F00D; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (2) @(negedge clk);
    chk("wfirst_wready", {31'b0, wready}, 32'h0);
    chk("wfirst_awready", {31'b0, awready}, 32'h1);
    awaddr = 32'h8; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("wfirst_bvalid", {31'b0, bvalid}, 32'h1);
    @(negedge clk);
    $display("WRITE addr=00000008 data=cafef00d (W first)");
    do_read(32'h8, 2, rd);
    chk("read_0x8", rd, 32'hCAFE_F00D);

    // ---- out of range ----
    do_read(32'h4321_1234, 0, rd);
    chk("read_oor", rd, 32'h0);
    do_write(32'h40, 32'hDEAD_BEEF);
    do_read(32'h0, 0, rd);
    chk("reg0_unchanged", rd, 32'h1234_5678);

    // ---- write-response backpressure ----
    bready = 0;
    awaddr = 32'h10; wdata = 32'hA5A5_A5A5; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", {31'b0, bvalid}, 32'h1);
      chk("bp_awready", {31'b0, awready}, 32'h0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    chk("bp_awready_back", {31'b0, awready}, 32'h1);
    chk("bp_wready_back", {31'b0, wready}, 32'h1);
    $display("WRITE addr=00000010 data=a5a5a5a5 (backpressured)");
    do_read(32'h10, 0, rd);
    chk("read_0x10", rd, 32'hA5A5_A5A5);

    // ---- same-edge write commit and read ----
    do_write(32'h4, 32'h1111_1111);
    awaddr = 32'h4; wdata = 32'h2222_2222; araddr = 32'h4;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("conflict_rdata", rdata, 32'h1111_1111);
    chk("conflict_bvalid", {31'b0, bvalid}, 32'h1);
    @(negedge clk);
    $display("WRITE addr=00000004 data=22222222 with READ same edge data=%h", rdata);
    do_read(32'h4, 0, rd);
    chk("read_0x4_new", rd, 32'h2222_2222);

    // ---- reset in the middle of a write ----
    awaddr = 32'hC; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    reset = 1;
    #1;
    chk("mid_rst_awready", {31'b0, awready}, 32'h0);
    chk("mid_rst_wready", {31'b0, wready}, 32'h0);
    chk("mid_rst_arready", {31'b0, arready}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    do_read(32'h0, 0, rd);
    chk("post_rst_0x0", rd, 32'h0);
    do_read(32'h8, 0, rd);
    chk("post_rst_0x8", rd, 32'h0);
    do_write(32'hC, 32'h0000_0077);
    do_read(32'hC, 0, rd);
    chk("post_rst_0xC", rd, 32'h0000_0077);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_slave_regfile.md
# axi4_slave_regfile

AXI4-style slave that terminates the single-beat write and read transactions issued by `axi4_master` and backs them with a small word-addressed register file. It sits directly downstream of the master on the same five channels. It accepts the write address and write data in any order and returns a write response. It serves reads with one-cycle latency and holds every response until the master accepts it.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NUM_REGS`, 16, number of 32-bit registers; power of two, minimum 2
- `BASE_ADDR`, 32'h0000_0000, byte address of register 0; aligned to 4*NUM_REGS

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `awaddr`  in  ADDR_W  write address
- `awvalid`  in  1  write address valid
- `awready`  out  1  slave can accept write address
- `wdata`  in  DATA_W  write data
- `wvalid`  in  1  write data valid
- `wready`  out  1  slave can accept write data
- `bvalid`  out  1  write response valid
- `bready`  in  1  master accepts write response
- `araddr`  in  ADDR_W  read address
- `arvalid`  in  1  read address valid
- `arready`  out  1  slave can accept read address
- `rdata`  out  DATA_W  read data
- `rvalid`  out  1  read data valid
- `rready`  in  1  master accepts read data

## Operation
- All outputs are registered.
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0. All registers clear to 0 and pending captures are discarded.
- Register index: `(addr - BASE_ADDR) >> 2`. An address is in range when `BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS`. Without the macro, addr[1:0] is ignored.
- Write FSM:
  - WR_IDLE:
    - awready=1 until AW is captured; wready=1 until W is captured.
    - Each channel is captured independently on its valid&&ready edge.
    - At the edge where both captures are complete (same edge or later), the write commits to the register file (in-range only) and the FSM moves to WR_RESP.
    - awready and wready are 0 from that edge onward.
  - WR_RESP: bvalid=1, held stable until bready. On bvalid&&bready, the FSM clears bvalid, returns to WR_IDLE, and sets awready=wready=1 at the same edge.
  - Out-of-range writes are dropped silently and still receive a response.
- Read FSM:
  - RD_IDLE: arready=1.
    - On arvalid&&arready, the FSM samples the register (0 if out of range) into rdata, sets rvalid=1, clears arready, and moves to RD_DATA.
  - RD_DATA: rdata and rvalid are held stable until rready. On rvalid&&rready, the FSM clears rvalid, sets arready=1, and returns to RD_IDLE.
- The read and write FSMs are fully independent and may be active simultaneously.
- Same-edge conflict: when a write commits and an AR is captured to the same register on the same edge, rdata returns the old value.

## Timing
- The first ready is asserted on the first clock edge after reset deasserts.
- Write, AW and W handshake on the same edge N: bvalid=1 from N+1; if bready=1, awready/wready=1 again from N+2. Sustained rate is one write per 2 cycles.
- Write, AW at edge N and W at edge M>N: awready=0 from N+1; bvalid=1 from M+1.
- Read: AR at edge N gives rvalid from N+1. With rready=1, arready=1 again from N+2.
- Backpressure: bvalid/rvalid persist indefinitely while the matching ready is low, and no new transaction of that direction is accepted.
- Reset asserted mid-transaction clears everything immediately (async). A committed write is lost only via the register clear.

## Configuration
- `AXI4_SLAVE_RESP_EN`, when defined:
  - Adds ports `bresp` (out, 2) and `rresp` (out, 2), both reset to 2'b00 and valid with bvalid/rvalid.
  - The response is OKAY (2'b00) for an in-range, aligned address.
  - The response is SLVERR (2'b10) for an out-of-range address or addr[1:0]!=0. Such writes are dropped and such reads return rdata=0.
- When undefined: no resp ports, and misalignment is ignored.

## Test plan
- Aligned write then read: AW 0x0 and W 0x1234_5678 on the same edge, bready=1 → bvalid one cycle later. Then AR 0x0 → rvalid next cycle, rdata=0x1234_5678.
- W before AW: W 0xCAFE_F00D at cycle 2, AW 0x8 at cycle 5 → wready=0 from cycle 3, bvalid at cycle 6. A subsequent read of 0x8 returns 0xCAFE_F00D.
- Out-of-range read: AR 0x4321_1234 → rdata=0x0. With `AXI4_SLAVE_RESP_EN`, rresp=2'b10; otherwise no resp port. A write to 0x40 is dropped, and the register at 0x0 is unchanged.
- Backpressure: hold bready=0 for 5 cycles after a write → bvalid stays 1 and awready/wready stay 0 throughout. bready=1 → readies return 1 the following cycle.
- Same-edge conflict: the register at 0x4 holds 0x1111_1111. Commit a write of 0x2222_2222 to 0x4 on the edge AR 0x4 is accepted → rdata=0x1111_1111. A later read returns 0x2222_2222.
- Reset mid-write: assert reset after AW capture and before W → all outputs 0 immediately and registers read 0 after release. A fresh write completes normally.
